i2c_slave_regfile: RTL and testbench

- I2C target device that sits on the SCL/SDA bus directly downstream of the team's I2C master.
- Decodes START, 7-bit device address, R/W, register address, write data and repeated-START reads.
- Backs them with an internal byte-wide register file and exposes a write-strobe side port for system logic.
- Also used as the bus-functional partner when verifying the master.

---
 rtl/i2c_slave_regfile.sv | 259 +++++++++++++++++++++++++
 tb/tb_i2c_slave_regfile.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_regfile.sv
//==============================================================================
// Module      : i2c_slave_regfile
// Description : I2C target with a byte-wide register file. Decodes START/STOP,
//               7-bit device address + R/W, register address, write data and
//               repeated-START reads. Committed writes are mirrored on a
//               one-cycle write-strobe side port.
// Ports       : clk            system clock
//               rst            synchronous reset, active low
//               SCL_in/SDA_in  bus clock / bus data as seen on the wire
//               SDA_out        target drive (0 = pull low, 1 = release)
//               wr_stb         one-cycle pulse per committed data byte
//               wr_addr        register address of the committed byte
//               wr_data        committed byte
//               busy           address-matched transfer in progress
// Options     : define I2C_SLV_TIMEOUT_EN to abort a transfer once synchronised
//               SCL has been low for TIMEOUT_CYCLES clk while busy.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module i2c_slave_regfile #(
    parameter logic [6:0] DEV_ADDR       = 7'h50,
    parameter int         REG_DEPTH      = 16,
    parameter int         SYNC_STAGES    = 2,
    parameter int         TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       SCL_in,
    input  logic       SDA_in,
    output logic       SDA_out,
    output logic       wr_stb,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy
);

    localparam int               c_PTR_W   = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;
    localparam logic [c_PTR_W-1:0] c_PTR_MAX = c_PTR_W'(REG_DEPTH - 1);
    localparam logic [8:0]       c_DEPTH9  = 9'(REG_DEPTH);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_DEV      = 4'd1,
        S_ACK_DEV  = 4'd2,
        S_REG      = 4'd3,
        S_ACK_REG  = 4'd4,
        S_WR_DATA  = 4'd5,
        S_ACK_DATA = 4'd6,
        S_RD_DATA  = 4'd7,
        S_RD_ACK   = 4'd8
    } state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_prev;
    logic                   r_sda_prev;
    logic [7:0]             r_shift;
    logic [2:0]             r_bitcnt;
    logic                   r_rw;
    logic                   r_phase;     // ACK states: 0 = waiting to drive, 1 = driving
    logic [c_PTR_W-1:0]     r_ptr;
    logic [7:0]             r_mem [REG_DEPTH];

    logic w_scl, w_sda, w_scl_rise, w_scl_fall, w_start, w_stop, w_timeout;
    logic [7:0]         w_byte;
    logic [c_PTR_W-1:0] w_ptr_inc;

    // Bus lines idle high, so the synchronisers reset to 1 to avoid phantom edges.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], SCL_in};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], SDA_in};
            r_scl_prev <= w_scl;
            r_sda_prev <= w_sda;
        end
    end

    assign w_scl      = r_scl_sync[SYNC_STAGES-1];
    assign w_sda      = r_sda_sync[SYNC_STAGES-1];
    assign w_scl_rise = w_scl & ~r_scl_prev;
    assign w_scl_fall = ~w_scl & r_scl_prev;
    // SCL must be high both before and after the SDA transition.
    assign w_start    = w_scl & r_scl_prev & r_sda_prev & ~w_sda;
    assign w_stop     = w_scl & r_scl_prev & ~r_sda_prev & w_sda;
    assign w_byte     = {r_shift[6:0], w_sda};
    assign w_ptr_inc  = (r_ptr == c_PTR_MAX) ? '0 : r_ptr + 1'b1;

`ifdef I2C_SLV_TIMEOUT_EN
    localparam int c_TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [c_TO_W-1:0] r_to_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_to_cnt <= '0;
        end else if (!w_scl && busy) begin
            if (r_to_cnt != c_TO_W'(TIMEOUT_CYCLES)) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
        end else begin
            r_to_cnt <= '0;
        end
    end

    assign w_timeout = (r_to_cnt == c_TO_W'(TIMEOUT_CYCLES));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_shift  <= '0;
            r_bitcnt <= '0;
            r_rw     <= 1'b0;
            r_phase  <= 1'b0;
            r_ptr    <= '0;
            SDA_out  <= 1'b1;
            wr_stb   <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            busy     <= 1'b0;
            for (int i = 0; i < REG_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            wr_stb <= 1'b0;
            if (w_stop || w_timeout) begin
                r_state <= S_IDLE;
                SDA_out <= 1'b1;
                busy    <= 1'b0;
                r_phase <= 1'b0;
            end else if (w_start) begin
                // Repeated START keeps the pointer so a following read resumes there.
                r_state  <= S_DEV;
                r_bitcnt <= 3'd7;
                SDA_out  <= 1'b1;
                r_phase  <= 1'b0;
            end else begin
                case (r_state)
                    S_DEV: if (w_scl_rise) begin
                        r_shift <= w_byte;
                        if (r_bitcnt == 3'd0) begin
                            if (w_byte[7:1] == DEV_ADDR) begin
                                r_state <= S_ACK_DEV;
                                r_rw    <= w_byte[0];
                                busy    <= 1'b1;
                            end else begin
                                r_state <= S_IDLE;
                                busy    <= 1'b0;
                            end
                        end else begin
                            r_bitcnt <= r_bitcnt - 1'b1;
                        end
                    end
                    S_ACK_DEV: if (w_scl_fall) begin
                        if (!r_phase) begin
                            SDA_out <= 1'b0;
                            r_phase <= 1'b1;
                        end else begin
                            r_phase  <= 1'b0;
                            r_bitcnt <= 3'd7;
                            if (r_rw) begin
                                // First read bit goes out on the fall that ends the ACK.
                                SDA_out <= r_mem[r_ptr][7];
                                r_shift <= {r_mem[r_ptr][6:0], 1'b0};
                                r_state <= S_RD_DATA;
                            end else begin
                                SDA_out <= 1'b1;
                                r_state <= S_REG;
                            end
                        end
                    end
                    S_REG: if (w_scl_rise) begin
                        r_shift <= w_byte;
                        if (r_bitcnt == 3'd0) begin
                            if ({1'b0, w_byte} < c_DEPTH9) begin
                                r_ptr   <= w_byte[c_PTR_W-1:0];
                                r_state <= S_ACK_REG;
                            end else begin
                                r_state <= S_IDLE;
                                busy    <= 1'b0;
                            end
                        end else begin
                            r_bitcnt <= r_bitcnt - 1'b1;
                        end
                    end
                    S_ACK_REG, S_ACK_DATA: if (w_scl_fall) begin
                        if (!r_phase) begin
                            SDA_out <= 1'b0;
                            r_phase <= 1'b1;
                        end else begin
                            SDA_out  <= 1'b1;
                            r_phase  <= 1'b0;
                            r_bitcnt <= 3'd7;
                            r_state  <= S_WR_DATA;
                            if (r_state == S_ACK_DATA) begin
                                r_ptr <= w_ptr_inc;
                            end
                        end
                    end
                    S_WR_DATA: if (w_scl_rise) begin
                        r_shift <= w_byte;
                        if (r_bitcnt == 3'd0) begin
                            r_mem[r_ptr] <= w_byte;
                            wr_stb       <= 1'b1;
                            wr_addr      <= 8'(r_ptr);
                            wr_data      <= w_byte;
                            r_phase      <= 1'b0;
                            r_state      <= S_ACK_DATA;
                        end else begin
                            r_bitcnt <= r_bitcnt - 1'b1;
                        end
                    end
                    S_RD_DATA: if (w_scl_fall) begin
                        if (r_bitcnt != 3'd0) begin
                            SDA_out  <= r_shift[7];
                            r_shift  <= {r_shift[6:0], 1'b0};
                            r_bitcnt <= r_bitcnt - 1'b1;
                        end else begin
                            SDA_out <= 1'b1;
                            r_phase <= 1'b0;
                            r_state <= S_RD_ACK;
                        end
                    end
                    S_RD_ACK: begin
                        if (w_scl_rise) begin
                            if (!w_sda) begin
                                r_ptr   <= w_ptr_inc;
                                r_phase <= 1'b1;
                            end else begin
                                r_state <= S_IDLE;
                                busy    <= 1'b0;
                            end
                        end else if (w_scl_fall && r_phase) begin
                            SDA_out  <= r_mem[r_ptr][7];
                            r_shift  <= {r_mem[r_ptr][6:0], 1'b0};
                            r_bitcnt <= 3'd7;
                            r_phase  <= 1'b0;
                            r_state  <= S_RD_DATA;
                        end
                    end
                    default: begin
                        SDA_out <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_i2c_slave_regfile.sv
`timescale 1ns/1ps
`default_nettype none

module tb_i2c_slave_regfile;

    logic       clk   = 1'b0;
    logic       rst   = 1'b0;
    logic       scl   = 1'b1;
    logic       sda_m = 1'b1;
    logic       w_sda;
    logic       sda_out, wr_stb, busy;
    logic [7:0] wr_addr, wr_data;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [15:0] sb_q[$];

    // Open-drain wire: either side can pull low.
    assign w_sda = sda_m & sda_out;

    always #5 clk = ~clk;

    i2c_slave_regfile #(
        .DEV_ADDR      (7'h50),
        .REG_DEPTH     (16),
        .SYNC_STAGES   (2),
        .TIMEOUT_CYCLES(1024)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .SCL_in (scl),
        .SDA_in (w_sda),
        .SDA_out(sda_out),
        .wr_stb (wr_stb),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .busy   (busy)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Scoreboard: every strobe must match the oldest expected (addr,data).
    always @(negedge clk) begin
        if (rst && wr_stb) begin
            check_val("stb_expected", 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0) begin
                check_val("stb_addr_data", 32'({wr_addr, wr_data}), 32'(sb_q.pop_front()));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One SCL period: drive b during low, sample the wire mid-high.
    task automatic bit_cycle(input logic b, output logic s);
        sda_m = b;
        wait_clk(4);
        scl = 1'b1;
        wait_clk(4);
        s = w_sda;
        wait_clk(4);
        scl = 1'b0;
        wait_clk(4);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1;
        wait_clk(4);
        scl = 1'b1;
        wait_clk(4);
        sda_m = 1'b0;
        wait_clk(4);
        scl = 1'b0;
        wait_clk(4);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0;
        wait_clk(4);
        scl = 1'b1;
        wait_clk(4);
        sda_m = 1'b1;
        wait_clk(4);
    endtask

    task automatic wr_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_cycle(b[i], s);
        end
        bit_cycle(1'b1, ack);
    endtask

    task automatic rd_byte(input logic nack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_cycle(1'b1, s);
            d[i] = s;
        end
        bit_cycle(nack, s);
    endtask

    // Address + register pointer phase of a write transaction.
    task automatic wr_hdr(input string tag, input logic [7:0] reg_a);
        logic ack;
        i2c_start();
        wr_byte(8'hA0, ack);
        check_val({tag, "_dev_ack"}, 32'(ack), 32'd0);
        wr_byte(reg_a, ack);
        check_val({tag, "_reg_ack"}, 32'(ack), 32'd0);
    endtask

    task automatic wr_data_byte(input string tag, input logic [7:0] reg_a, input logic [7:0] d);
        logic ack;
        sb_q.push_back({reg_a, d});
        wr_byte(d, ack);
        check_val({tag, "_data_ack"}, 32'(ack), 32'd0);
    endtask

    initial begin
        logic       ack, s;
        logic [7:0] d;

        wait_clk(3);
        check_val("reset_sda_out", 32'(sda_out), 32'd1);
        check_val("reset_busy",    32'(busy),    32'd0);
        check_val("reset_wr_stb",  32'(wr_stb),  32'd0);
        check_val("reset_wr_addr", 32'(wr_addr), 32'd0);
        check_val("reset_wr_data", 32'(wr_data), 32'd0);
        rst = 1'b1;
        wait_clk(4);

        // Basic single write.
        wr_hdr("t1", 8'h03);
        wr_data_byte("t1", 8'h03, 8'hA5);
        check_val("t1_busy_before_stop", 32'(busy), 32'd1);
        i2c_stop();
        check_val("t1_busy_after_stop", 32'(busy), 32'd0);
        check_val("t1_sda_after_stop", 32'(sda_out), 32'd1);

        // Pointer wrap on consecutive writes.
        wr_hdr("t2", 8'h0F);
        wr_data_byte("t2a", 8'h0F, 8'h11);
        wr_data_byte("t2b", 8'h00, 8'h22);
        i2c_stop();

        // Preload reg 5, then write-pointer / Sr / read with NACK.
        wr_hdr("t3w", 8'h05);
        wr_data_byte("t3w", 8'h05, 8'h3C);
        i2c_stop();
        wr_hdr("t3r", 8'h05);
        i2c_start();
        wr_byte(8'hA1, ack);
        check_val("t3_rd_dev_ack", 32'(ack), 32'd0);
        rd_byte(1'b1, d);
        check_val("t3_rd_data", 32'(d), 32'h3C);
        check_val("t3_busy_after_nack", 32'(busy), 32'd0);
        i2c_stop();

        // Multi-byte read across the pointer wrap.
        wr_hdr("t4r", 8'h0F);
        i2c_start();
        wr_byte(8'hA1, ack);
        check_val("t4_rd_dev_ack", 32'(ack), 32'd0);
        rd_byte(1'b0, d);
        check_val("t4_rd_data0", 32'(d), 32'h11);
        rd_byte(1'b1, d);
        check_val("t4_rd_data1", 32'(d), 32'h22);
        i2c_stop();

        // Wrong device address.
        i2c_start();
        wr_byte(8'hA2, ack);
        check_val("t5_bad_dev_nack", 32'(ack), 32'd1);
        check_val("t5_busy", 32'(busy), 32'd0);
        wr_byte(8'h01, ack);
        check_val("t5_follow_nack", 32'(ack), 32'd1);
        i2c_stop();

        // Out-of-range register addresses.
        i2c_start();
        wr_byte(8'hA0, ack);
        check_val("t6_dev_ack", 32'(ack), 32'd0);
        wr_byte(8'h20, ack);
        check_val("t6_reg20_nack", 32'(ack), 32'd1);
        wr_byte(8'h77, ack);
        check_val("t6_data_ignored", 32'(ack), 32'd1);
        check_val("t6_busy", 32'(busy), 32'd0);
        i2c_stop();
        i2c_start();
        wr_byte(8'hA0, ack);
        wr_byte(8'h10, ack);
        check_val("t6_reg10_nack", 32'(ack), 32'd1);
        i2c_stop();

        // STOP after 4 data bits: no commit.
        wr_hdr("t7", 8'h02);
        for (int i = 0; i < 4; i++) begin
            bit_cycle(1'b1, s);
        end
        i2c_stop();
        check_val("t7_busy_after_stop", 32'(busy), 32'd0);
        check_val("t7_sda_after_stop", 32'(sda_out), 32'd1);

        // Reset mid-byte on a second transfer.
        wr_hdr("t8", 8'h02);
        for (int i = 0; i < 4; i++) begin
            bit_cycle(1'b0, s);
        end
        rst = 1'b0;
        wait_clk(1);
        check_val("t8_sda_after_rst", 32'(sda_out), 32'd1);
        check_val("t8_busy_after_rst", 32'(busy), 32'd0);
        rst = 1'b1;
        sda_m = 1'b1;
        wait_clk(4);
        scl = 1'b1;
        wait_clk(8);

        // Registers were cleared by the reset.
        wr_hdr("t9", 8'h05);
        i2c_start();
        wr_byte(8'hA1, ack);
        check_val("t9_rd_dev_ack", 32'(ack), 32'd0);
        rd_byte(1'b1, d);
        check_val("t9_reg5_cleared", 32'(d), 32'h00);
        i2c_stop();

`ifdef I2C_SLV_TIMEOUT_EN
        i2c_start();
        wr_byte(8'hA0, ack);
        check_val("t10_dev_ack", 32'(ack), 32'd0);
        check_val("t10_busy_before", 32'(busy), 32'd1);
        wait_clk(1100);
        check_val("t10_busy_timeout", 32'(busy), 32'd0);
        check_val("t10_sda_timeout", 32'(sda_out), 32'd1);
        sda_m = 1'b1;
        scl = 1'b1;
        wait_clk(8);
`endif

        wait_clk(8);
        check_val("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
